if_stage: RTL and testbench

- Parametrised instruction-fetch front end for the pipelined MIPS core.
- Replaces the free-running PC/adder pair with four pieces: a start-gated PC, branch redirect, hazard stall, and an integrated IF/ID pipeline register.
- Drives the combinational instruction memory address and presents a registered {pc+step, instruction, valid} bundle to the decode stage.
- Supports a squash-on-branch mode and a branch-delay-slot mode.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/ifid_reg.sv | 41 ++++
 rtl/if_stage.sv | 78 +++++++
 tb/tb_if_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS core: state encodings, the NOP
// instruction, default datapath widths and a small log2 helper.
package cpu_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [DEF_INST_W-1:0] NOP_INST = '0;

    // Exact log2 of a power-of-two step; used to align branch targets.
    function automatic int step_log2(input int step);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) == step) begin
                result = i;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register carrying {pc, inst, valid} between stages.
// hold freezes everything, bubble inserts a NOP, load captures new fields.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter int PC_W   = DEF_ADDR_W,
    parameter int INST_W = DEF_INST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              hold,
    input  logic              bubble,
    input  logic [PC_W-1:0]   next_pc,
    input  logic [INST_W-1:0] next_inst,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] inst,
    output logic              valid
);

    localparam logic [INST_W-1:0] NOP = INST_W'(NOP_INST);

    // A bubble keeps the old pc so downstream debug still sees the last real address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= '0;
            inst  <= NOP;
            valid <= 1'b0;
        end else if (!hold) begin
            if (bubble) begin
                inst  <= NOP;
                valid <= 1'b0;
            end else if (load) begin
                pc    <= next_pc;
                inst  <= next_inst;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch front end: start-gated PC with branch redirect and hazard
// stall, feeding an integrated IF/ID register.
module if_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W          = DEF_ADDR_W,
    parameter int                INST_W          = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0,
    parameter int                PC_STEP         = 4,
    parameter bit                FLUSH_ON_BRANCH = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [INST_W-1:0] imem_inst_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              valid_o,
    output logic              running_o
);

    localparam int                STEP_LOG   = step_log2(PC_STEP);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << STEP_LOG) - 64'd1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus;
    logic              fetch_active;
    logic              take_branch;
    logic              take_stall;
    logic              ifid_bubble;

    assign pc_plus      = pc + STEP;
    assign fetch_active = (state == RUN) && start_i;
    assign take_branch  = fetch_active && branch_i;
    assign take_stall   = fetch_active && !branch_i && stall_i;
    assign ifid_bubble  = !fetch_active || (take_branch && FLUSH_ON_BRANCH);

    // Dropping start_i only parks the FSM; the PC is kept so fetch resumes in place.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= start_i ? RUN : IDLE;
            if (take_branch) begin
                pc <= branch_target_i & ALIGN_MASK;
            end else if (fetch_active && !take_stall) begin
                pc <= pc_plus;
            end
        end
    end

    ifid_reg #(
        .PC_W   (ADDR_W),
        .INST_W (INST_W)
    ) u_ifid (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .load      (fetch_active),
        .hold      (take_stall),
        .bubble    (ifid_bubble),
        .next_pc   (pc_plus),
        .next_inst (imem_inst_i),
        .pc        (pc_o),
        .inst      (inst_o),
        .valid     (valid_o)
    );

    assign imem_addr_o = pc;
    assign running_o   = (state == RUN);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: squash, delay-slot and wrap-around configurations,
// each with instruction memory returning inst = addr.
module tb_if_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the squash (a) and delay-slot (b) instances.
    logic        rst = 1'b0, start = 1'b0, stall = 1'b0, branch = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] addr_a, inst_a, pc_a, addr_b, inst_b, pc_b;
    logic        valid_a, run_a, valid_b, run_b;

    // Wrap instance (c) has its own controls.
    logic        rst_c = 1'b0, start_c = 1'b0;
    logic [31:0] addr_c, inst_c, pc_c;
    logic        valid_c, run_c;

    int checks = 0;
    int passed = 0;

    if_stage #(.FLUSH_ON_BRANCH(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
        .branch_target_i(target), .imem_addr_o(addr_a), .imem_inst_i(addr_a),
        .pc_o(pc_a), .inst_o(inst_a), .valid_o(valid_a), .running_o(run_a)
    );

    if_stage #(.FLUSH_ON_BRANCH(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
        .branch_target_i(target), .imem_addr_o(addr_b), .imem_inst_i(addr_b),
        .pc_o(pc_b), .inst_o(inst_b), .valid_o(valid_b), .running_o(run_b)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8), .FLUSH_ON_BRANCH(1'b1)) dut_c (
        .clk_i(clk), .rst_i(rst_c), .start_i(start_c), .stall_i(1'b0), .branch_i(1'b0),
        .branch_target_i(32'h0), .imem_addr_o(addr_c), .imem_inst_i(addr_c),
        .pc_o(pc_c), .inst_o(inst_c), .valid_o(valid_c), .running_o(run_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_a(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                           input logic [31:0] inst, input logic valid);
        check({tag, ".a.addr"},  addr_a,  addr);
        check({tag, ".a.pc"},    pc_a,    pc);
        check({tag, ".a.inst"},  inst_a,  inst);
        check({tag, ".a.valid"}, {31'b0, valid_a}, {31'b0, valid});
    endtask

    task automatic check_b(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                           input logic [31:0] inst, input logic valid);
        check({tag, ".b.addr"},  addr_b,  addr);
        check({tag, ".b.pc"},    pc_b,    pc);
        check({tag, ".b.inst"},  inst_b,  inst);
        check({tag, ".b.valid"}, {31'b0, valid_b}, {31'b0, valid});
    endtask

    task automatic check_c(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                           input logic [31:0] inst, input logic valid, input logic running);
        check({tag, ".c.addr"},    addr_c,  addr);
        check({tag, ".c.pc"},      pc_c,    pc);
        check({tag, ".c.inst"},    inst_c,  inst);
        check({tag, ".c.valid"},   {31'b0, valid_c}, {31'b0, valid});
        check({tag, ".c.running"}, {31'b0, run_c},   {31'b0, running});
    endtask

    initial begin
        // Reset held for two edges.
        step();
        step();
        check_a("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check_b("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("reset.a.running", {31'b0, run_a}, 32'h0);
        check_c("reset", 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 1'b0);

        rst = 1'b1; start = 1'b1;
        step();
        check_a("start1", 32'h0, 32'h0, 32'h0, 1'b0);
        check("start1.a.running", {31'b0, run_a}, 32'h1);
        step();
        check_a("fetch0", 32'h4, 32'h4, 32'h0, 1'b1);
        step();
        check_a("fetch4", 32'h8, 32'h8, 32'h4, 1'b1);
        step();
        check_a("fetch8", 32'hC, 32'hC, 32'h8, 1'b1);
        check_b("fetch8", 32'hC, 32'hC, 32'h8, 1'b1);

        // Taken branch to 0x40 while fetching 0x0C.
        branch = 1'b1; target = 32'h40;
        step();
        check_a("br40", 32'h40, 32'hC, 32'h0, 1'b0);
        check_b("br40", 32'h40, 32'h10, 32'hC, 1'b1);
        branch = 1'b0;
        step();
        check_a("after_br40", 32'h44, 32'h44, 32'h40, 1'b1);
        check_b("after_br40", 32'h44, 32'h44, 32'h40, 1'b1);

        // Redirect to 0x10 then stall there for three cycles.
        branch = 1'b1; target = 32'h10;
        step();
        check_a("br10", 32'h10, 32'h44, 32'h0, 1'b0);
        check_b("br10", 32'h10, 32'h48, 32'h44, 1'b1);
        branch = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_a("stall", 32'h10, 32'h44, 32'h0, 1'b0);
            check_b("stall", 32'h10, 32'h48, 32'h44, 1'b1);
        end
        stall = 1'b0;
        step();
        check_a("unstall", 32'h14, 32'h14, 32'h10, 1'b1);
        check_b("unstall", 32'h14, 32'h14, 32'h10, 1'b1);

        // Branch and stall together; misaligned target is cleared to 0x80.
        branch = 1'b1; stall = 1'b1; target = 32'h81;
        step();
        check_a("br_stall", 32'h80, 32'h14, 32'h0, 1'b0);
        check_b("br_stall", 32'h80, 32'h18, 32'h14, 1'b1);
        branch = 1'b0; stall = 1'b0;
        step();
        check_a("after_br_stall", 32'h84, 32'h84, 32'h80, 1'b1);
        check_b("after_br_stall", 32'h84, 32'h84, 32'h80, 1'b1);

        // Wrap-around instance.
        rst_c = 1'b1; start_c = 1'b1;
        step();
        check_c("c_start", 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        check_c("c_f8", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 1'b1, 1'b1);
        step();
        check_c("c_fc", 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b1);
        step();
        check_c("c_0", 32'h4, 32'h4, 32'h0, 1'b1, 1'b1);

        start_c = 1'b0;
        step();
        check_c("c_stop", 32'h4, 32'h4, 32'h0, 1'b0, 1'b0);
        step();
        check_c("c_idle", 32'h4, 32'h4, 32'h0, 1'b0, 1'b0);

        start_c = 1'b1;
        step();
        check_c("c_restart", 32'h4, 32'h4, 32'h0, 1'b0, 1'b1);
        step();
        check_c("c_resume", 32'h8, 32'h8, 32'h4, 1'b1, 1'b1);

        rst_c = 1'b0;
        step();
        check_c("c_midreset", 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
